// File: rtl/transform_pkg.sv
// Shared definitions for the transform printer: ASCII constants, the printer
// state enum and the UART frame length.
// Optional feature macro: TRANSFORM_PRINTER_PARITY_EN (even parity bit per frame).
package transform_pkg;

  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] EQUALS = 8'h3D;
  localparam logic [7:0] GT     = 8'h3E;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;

`ifdef TRANSFORM_PRINTER_PARITY_EN
  // start + 8 data + parity + stop
  localparam int unsigned FRAME_BITS = 11;
`else
  // start + 8 data + stop
  localparam int unsigned FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LHS,
    ST_SEP,
    ST_RHS,
    ST_EOL
  } tp_state_e;

  // Characters of the " => " separator, indexed in send order.
  function automatic logic [7:0] sep_char(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = SPACE;
      2'd1:    c = EQUALS;
      2'd2:    c = GT;
      default: c = SPACE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/transform_printer_uart_tx.sv
// Byte-wide UART serializer: start bit, 8 data bits LSB first, optional even
// parity, stop bit. byte_ready_o is also high in the last cycle of a stop bit
// so a byte offered then starts its frame with no idle gap.
// Optional feature macro: TRANSFORM_PRINTER_PARITY_EN.
module uart_tx
  import transform_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       byte_ready_o,
  output logic       idle_o,
  output logic       tx_o
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PAY_W  = FRAME_BITS - 1;

  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [PAY_W-1:0]  shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              tx_q, tx_d;

  logic              baud_end;
  logic              last_tick;
  logic              accept;
  logic [PAY_W-1:0]  payload;

  assign baud_end     = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_tick    = busy_q && baud_end && (bit_q == 4'(FRAME_BITS - 1));
  assign byte_ready_o = !busy_q || last_tick;
  assign accept       = byte_valid_i && byte_ready_o;
  assign idle_o       = !busy_q;
  assign tx_o         = tx_q;

`ifdef TRANSFORM_PRINTER_PARITY_EN
  assign payload = {1'b1, ^byte_i, byte_i};
`else
  assign payload = {1'b1, byte_i};
`endif

  // Bit sequencing: load on accept, otherwise advance one bit per baud period.
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    tx_d    = tx_q;
    if (accept) begin
      busy_d  = 1'b1;
      tx_d    = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = payload;
    end else if (busy_q) begin
      if (baud_end) begin
        baud_d = '0;
        if (bit_q == 4'(FRAME_BITS - 1)) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[PAY_W-1:1]};
        end
      end else begin
        baud_d = baud_q + BAUD_W'(1);
      end
    end
  end

  // Serializer state; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/transform_printer.sv
// Transform printer: echoes lhs chars over UART as they arrive, buffers rhs
// chars, then prints " => ", the buffered rhs chars and CR LF.
// Optional feature macro: TRANSFORM_PRINTER_PARITY_EN (passed to uart_tx).
module transform_printer
  import transform_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned RHS_DEPTH    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pair_valid,
  output logic       pair_ready,
  input  logic [7:0] lhs,
  input  logic [7:0] rhs,
  input  logic       pair_last,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(RHS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  tp_state_e        state_q, state_d;
  logic [1:0]       sep_idx_q, sep_idx_d;
  logic             last_q, last_d;
  logic             lf_sent_q, lf_sent_d;
  logic             rdy_en_q;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       mem_q [RHS_DEPTH];

  logic             fire;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             tx_valid;
  logic [7:0]       tx_byte;
  logic             tx_ready;
  logic             tx_idle;

  assign full       = (count_q == CNT_W'(RHS_DEPTH));
  assign wr_en      = push && !full;
  assign pair_ready = rdy_en_q && tx_idle && !last_q &&
                      ((state_q == ST_IDLE) || (state_q == ST_LHS));
  assign fire       = pair_valid && pair_ready;
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = overflow_q;

  // Each state hands its next byte to the serializer in the same cycle it
  // becomes ready, so frames after the final lhs char run back-to-back and
  // the state changes as the last byte of each phase is accepted.
  always_comb begin
    state_d   = state_q;
    sep_idx_d = sep_idx_q;
    last_d    = last_q;
    lf_sent_d = lf_sent_q;
    tx_valid  = 1'b0;
    tx_byte   = '0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          tx_valid = 1'b1;
          tx_byte  = lhs;
          push     = 1'b1;
          last_d   = pair_last;
          state_d  = ST_LHS;
        end
      end
      ST_LHS: begin
        if (fire) begin
          tx_valid = 1'b1;
          tx_byte  = lhs;
          push     = 1'b1;
          last_d   = pair_last;
        end else if (last_q && tx_ready) begin
          tx_valid  = 1'b1;
          tx_byte   = sep_char(2'd0);
          sep_idx_d = 2'd1;
          last_d    = 1'b0;
          state_d   = ST_SEP;
        end
      end
      ST_SEP: begin
        if (tx_ready) begin
          tx_valid = 1'b1;
          tx_byte  = sep_char(sep_idx_q);
          if (sep_idx_q == 2'd3) begin
            sep_idx_d = 2'd0;
            state_d   = ST_RHS;
          end else begin
            sep_idx_d = sep_idx_q + 2'd1;
          end
        end
      end
      ST_RHS: begin
        if (tx_ready) begin
          tx_valid = 1'b1;
          if (count_q != '0) begin
            tx_byte = mem_q[rd_ptr_q];
            pop     = 1'b1;
          end else begin
            tx_byte   = CR;
            lf_sent_d = 1'b0;
            state_d   = ST_EOL;
          end
        end
      end
      ST_EOL: begin
        if (tx_ready) begin
          if (!lf_sent_q) begin
            tx_valid  = 1'b1;
            tx_byte   = LF;
            lf_sent_d = 1'b1;
          end else begin
            lf_sent_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rhs buffer bookkeeping; a push into a full buffer is dropped and flagged.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push && full);
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end
  end

  // Control and buffer-pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sep_idx_q  <= '0;
      last_q     <= 1'b0;
      lf_sent_q  <= 1'b0;
      rdy_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sep_idx_q  <= sep_idx_d;
      last_q     <= last_d;
      lf_sent_q  <= lf_sent_d;
      rdy_en_q   <= 1'b1;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // rhs storage; contents are meaningful only between rd and wr pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= rhs;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_valid_i(tx_valid),
    .byte_i      (tx_byte),
    .byte_ready_o(tx_ready),
    .idle_o      (tx_idle),
    .tx_o        (tx)
  );

endmodule

// File: tb/tb_transform_printer.sv
// Directed bench for transform_printer: a UART line monitor decodes tx into a
// byte queue and each scenario task compares against hand-computed bytes.
module tb_transform_printer;

  localparam int C  = 4;
  localparam int DEPTH = 4;
`ifdef TRANSFORM_PRINTER_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pair_valid = 1'b0;
  logic       pair_ready;
  logic [7:0] lhs = '0;
  logic [7:0] rhs = '0;
  logic       pair_last = 1'b0;
  logic       tx;
  logic       busy;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int unsigned xfer_cyc = 0;

  logic [7:0] rxq [$];
  logic       rxpar [$];
  int         frame_err = 0;
  int         ready_viol = 0;
  bit         in_frame = 1'b0;
  logic [7:0] mon_byte;
  logic       mon_par;
  bit         mon_ab;
  int         mon_off;

  transform_printer #(
    .CLKS_PER_BIT(C),
    .RHS_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pair_valid(pair_valid),
    .pair_ready(pair_ready),
    .lhs       (lhs),
    .rhs       (rhs),
    .pair_last (pair_last),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (in_frame && pair_ready === 1'b1) ready_viol++;

  // UART line monitor: detects a start bit, samples each bit mid-period,
  // abandons the frame if reset is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        mon_ab = 1'b0;
        mon_off = 0;
        mon_par = 1'b0;
        in_frame = 1'b1;
        for (int k = 1; k < FB; k++) begin
          while (mon_off < k * C + C / 2 && !mon_ab) begin
            @(negedge clk);
            mon_off++;
            if (rst_n !== 1'b1) mon_ab = 1'b1;
          end
          if (mon_ab) break;
          if (k <= 8) mon_byte[k-1] = tx;
          else if (k == FB - 1) begin
            if (tx !== 1'b1) frame_err++;
          end else mon_par = tx;
        end
        in_frame = 1'b0;
        if (!mon_ab) begin
          rxq.push_back(mon_byte);
          rxpar.push_back(mon_par);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_pair(input logic [7:0] l, input logic [7:0] r, input logic last);
    int n = 0;
    @(negedge clk);
    while (pair_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL pair_ready_wait: got pair_ready=%b expected 1 within 3000 cycles", pair_ready);
    end
    pair_valid = 1'b1;
    lhs = l;
    rhs = r;
    pair_last = last;
    @(posedge clk);
    #1;
    xfer_cyc = cyc;
    pair_valid = 1'b0;
    lhs = 8'hFF;
    rhs = 8'hFF;
    pair_last = 1'b0;
  endtask

  task automatic wait_idle(output int unsigned done_cyc, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 3000) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    done_cyc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", tx); end
    checks++; if (pair_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", pair_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    rst_n = 1'b1;
    #1;
    checks++; if (pair_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0", pair_ready); end
    @(posedge clk);
    #1;
    checks++; if (pair_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b expected 1", pair_ready); end
  endtask

  task automatic test_single();
    logic [7:0] exp_b [8] = '{8'h61, 8'h20, 8'h3D, 8'h3E, 8'h20, 8'h62, 8'h0D, 8'h0A};
    int unsigned done;
    bit ok;
    rxq.delete();
    rxpar.delete();
    drive_pair(8'h61, 8'h62, 1'b1);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start_bit: got tx=%b expected 0", tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    wait_idle(done, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle_timeout: got busy=%b expected 0", busy); end
    checks++;
    if (done - xfer_cyc !== 8 * FB * C) begin
      errors++;
      $display("FAIL single_duration: got %0d cycles expected %0d", done - xfer_cyc, 8 * FB * C);
    end
    checks++; if (rxq.size() !== 8) begin errors++; $display("FAIL single_count: got %0d bytes expected 8", rxq.size()); end
    for (int i = 0; i < 8 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", i, rxq[i], exp_b[i]); end
    end
`ifdef TRANSFORM_PRINTER_PARITY_EN
    checks++; if (rxpar.size() < 6 || rxpar[0] !== 1'b1) begin errors++; $display("FAIL parity_61: got %b expected 1", rxpar.size() > 0 ? rxpar[0] : 1'bx); end
    rxq.delete();
    rxpar.delete();
    drive_pair(8'h63, 8'h63, 1'b1);
    wait_idle(done, ok);
    checks++; if (rxpar.size() < 1 || rxpar[0] !== 1'b0) begin errors++; $display("FAIL parity_63: got %b expected 0", rxpar.size() > 0 ? rxpar[0] : 1'bx); end
`endif
  endtask

  task automatic test_sequence();
    logic [7:0] exp_b [12] = '{8'h31, 8'h74, 8'h32, 8'h20, 8'h3D, 8'h3E, 8'h20,
                               8'h31, 8'h74, 8'h5E, 8'h0D, 8'h0A};
    int unsigned done;
    bit ok;
    rxq.delete();
    ready_viol = 0;
    frame_err = 0;
    drive_pair(8'h31, 8'h31, 1'b0);
    // pulse while pair_ready is low: must leave no trace
    @(negedge clk);
    pair_valid = 1'b1; lhs = 8'h58; rhs = 8'h59; pair_last = 1'b1;
    @(negedge clk);
    pair_valid = 1'b0; pair_last = 1'b0;
    drive_pair(8'h74, 8'h74, 1'b0);
    drive_pair(8'h32, 8'h5E, 1'b1);
    wait_idle(done, ok);
    checks++; if (!ok) begin errors++; $display("FAIL seq_idle_timeout: got busy=%b expected 0", busy); end
    checks++; if (rxq.size() !== 12) begin errors++; $display("FAIL seq_count: got %0d bytes expected 12", rxq.size()); end
    for (int i = 0; i < 12 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== exp_b[i]) begin errors++; $display("FAIL seq_byte%0d: got %h expected %h", i, rxq[i], exp_b[i]); end
    end
    checks++; if (ready_viol !== 0) begin errors++; $display("FAIL seq_ready_in_frame: got %0d cycles expected 0", ready_viol); end
    checks++; if (frame_err !== 0) begin errors++; $display("FAIL seq_stop_bits: got %0d errors expected 0", frame_err); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b [15] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h3D, 8'h3E,
                               8'h20, 8'h61, 8'h62, 8'h63, 8'h64, 8'h0D, 8'h0A};
    logic [7:0] exp_w [8] = '{8'h46, 8'h20, 8'h3D, 8'h3E, 8'h20, 8'h66, 8'h0D, 8'h0A};
    int unsigned done;
    bit ok;
    rxq.delete();
    for (int i = 0; i < 4; i++) drive_pair(8'h41 + 8'(i), 8'h61 + 8'(i), 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full: got %b expected 0", overflow); end
    drive_pair(8'h45, 8'h65, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_on_drop: got %b expected 1", overflow); end
    wait_idle(done, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_idle_timeout: got busy=%b expected 0", busy); end
    checks++; if (rxq.size() !== 15) begin errors++; $display("FAIL ovf_count: got %0d bytes expected 15", rxq.size()); end
    for (int i = 0; i < 15 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== exp_b[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h expected %h", i, rxq[i], exp_b[i]); end
    end
    rxq.delete();
    drive_pair(8'h46, 8'h66, 1'b1);
    wait_idle(done, ok);
    checks++; if (rxq.size() !== 8) begin errors++; $display("FAIL wrap_count: got %0d bytes expected 8", rxq.size()); end
    for (int i = 0; i < 8 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== exp_w[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rxq[i], exp_w[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp_b [8] = '{8'h6B, 8'h20, 8'h3D, 8'h3E, 8'h20, 8'h6C, 8'h0D, 8'h0A};
    int unsigned done;
    bit ok;
    int viol = 0;
    rxq.delete();
    drive_pair(8'h48, 8'h49, 1'b1);
    repeat (14 * C + 2) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_tx_before_reset: got %b expected 0", tx); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx_reset: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_reset: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow_reset: got %b expected 0", overflow); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * C) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL mid_no_resume: got %0d active cycles expected 0", viol); end
    checks++;
    if (rxq.size() !== 1 || rxq[0] !== 8'h48) begin
      errors++;
      $display("FAIL mid_frames: got %0d bytes expected 1 (48)", rxq.size());
    end
    rxq.delete();
    drive_pair(8'h6B, 8'h6C, 1'b1);
    wait_idle(done, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_idle_timeout: got busy=%b expected 0", busy); end
    checks++; if (rxq.size() !== 8) begin errors++; $display("FAIL mid_count: got %0d bytes expected 8", rxq.size()); end
    for (int i = 0; i < 8 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== exp_b[i]) begin errors++; $display("FAIL mid_byte%0d: got %h expected %h", i, rxq[i], exp_b[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_overflow();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/transform_printer.md
TRANSFORM_PRINTER -- requirements
Module: transform_printer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit (>=2).
REQ-002 SHALL have parameter RHS_DEPTH, default 32, rhs buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port pair_valid  input  1  lhs/rhs/pair_last valid this cycle.
REQ-006 SHALL have port pair_ready  output  1  block accepts a pair this cycle.
REQ-007 SHALL have port lhs  input  8  ASCII char of input form.
REQ-008 SHALL have port rhs  input  8  ASCII char of transformed form.
REQ-009 SHALL have port pair_last  input  1  pair is final char of the transform line.
REQ-010 SHALL have port tx  output  1  UART serial out, idle high.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port overflow  output  1  sticky: an rhs char was dropped.

Function
REQ-013 SHALL transfer a pair only on a rising edge with pair_valid and pair_ready both high.
REQ-014 SHALL drive pair_ready high only in IDLE or LHS with the UART transmitter idle; low otherwise.
REQ-015 SHALL implement states IDLE, LHS, SEP, RHS, EOL.
REQ-016 IDLE->LHS on first transfer; LHS stays until a transfer with pair_last=1 and its lhs frame finished, then ->SEP.
REQ-017 SEP SHALL send 0x20, 0x3D, 0x3E, 0x20 (" => ") then ->RHS.
REQ-018 RHS SHALL send buffered rhs chars in arrival order until empty, then ->EOL; empty buffer goes directly to EOL.
REQ-019 EOL SHALL send 0x0D, 0x0A then ->IDLE.
REQ-020 Each transfer SHALL start the lhs frame (tx start bit low) on the cycle after the transfer edge, and push rhs into the buffer on that edge.
REQ-021 Frame: start 0, 8 data bits LSB first, stop 1, each bit exactly CLKS_PER_BIT cycles; frames back-to-back with no idle gap inside SEP/RHS/EOL.
REQ-022 Transfer with buffer full SHALL send lhs normally, discard rhs, set overflow=1.
REQ-023 overflow SHALL be cleared only by reset.
REQ-024 Buffer pointers SHALL wrap modulo RHS_DEPTH; count width clog2(RHS_DEPTH)+1.
REQ-025 pair_valid while pair_ready low SHALL be ignored without side effects; inputs need not be held.

Reset
REQ-026 rst_n low SHALL immediately force tx=1, pair_ready=0, busy=0, overflow=0, state IDLE, buffer empty, bit/baud counters zero.
REQ-027 Reset mid-frame SHALL abort the frame; no partial frame resumes after release.
REQ-028 pair_ready SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-029 Macro TRANSFORM_PRINTER_PARITY_EN defined: even parity bit inserted between data bit 7 and stop, frame 11 bits; undefined: no parity, frame 10 bits.

Structure
REQ-030 Shared package transform_pkg SHALL hold ASCII constants (SPACE, EQUALS, GT, CR, LF) and the printer state enum.
REQ-031 Serializer SHALL be sub-module uart_tx (byte valid/ready in, tx out, parity under same macro); FSM and rhs buffer stay in transform_printer.

Verification
REQ-032 Single pair lhs=0x61 rhs=0x62 last=1 -> tx bytes 61 20 3D 3E 20 62 0D 0A, 80*CLKS_PER_BIT cycles, then busy=0.
REQ-033 Pairs (31,31),(74,74),(32,5E) last on third -> bytes 31 74 32 20 3D 3E 20 31 74 5E 0D 0A; pair_ready low during every frame.
REQ-034 RHS_DEPTH+1 pairs in one line -> all lhs sent, first RHS_DEPTH rhs sent, last rhs dropped, overflow=1 until reset.
REQ-035 rst_n low at bit 4 of frame 2 -> tx=1 same cycle, busy=0, no further frames; new line after release prints correctly.
REQ-036 PARITY_EN defined, lhs=0x61 -> parity bit 1, frame 11*CLKS_PER_BIT cycles; lhs=0x63 -> parity bit 0.
